// File: rtl/lgi_pkg.sv
// Package: lgi_pkg
// Shared types and constants for logic_gate_identifier.
//   state_t      FSM states of the identification run
//   TT_*         reference truth tables of the selectable logic unit,
//                bit index = {a,b}
//   decode_t     decoded {valid, group, gate} result
//   decode_tt()  maps a captured truth table to its select code
package lgi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    typedef struct packed {
        logic valid;
        logic group;   // 0 = AND/NAND, 1 = OR/NOR
        logic gate;    // 0 = inverted, 1 = true
    } decode_t;

    // Unknown tables decode to all-zero so a broken unit never aliases to a
    // legal code with valid clear.
    function automatic decode_t decode_tt(input logic [3:0] tt);
        decode_t d;
        d = '0;
        case (tt)
            TT_AND:  d = '{valid: 1'b1, group: 1'b0, gate: 1'b1};
            TT_NAND: d = '{valid: 1'b1, group: 1'b0, gate: 1'b0};
            TT_OR:   d = '{valid: 1'b1, group: 1'b1, gate: 1'b1};
            TT_NOR:  d = '{valid: 1'b1, group: 1'b1, gate: 1'b0};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/logic_gate_identifier.sv
// Module: logic_gate_identifier
// Black-box identifier for the 2-input AND/NAND/OR/NOR selectable logic unit.
// Drives the unit with (a,b) = 00,01,10,11, captures its output into a
// 4-entry truth table and decodes the table back into {sel_group, sel_gate}.
//
// Parameters
//   SETTLE_CYCLES  extra cycles each vector is held before sampling (>=0)
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a run; only looked at in IDLE
//   probe_a/b    registered operands to the unit under identification
//   probe_y      unit output
//   busy         high in APPLY and DECODE
//   done         one-cycle pulse when results have been updated
//   truth_table  captured outputs, bit index = {a,b}
//   op_valid     table matched one of AND/NAND/OR/NOR
//   sel_group_o  decoded group (0 = AND/NAND, 1 = OR/NOR)
//   sel_gate_o   decoded gate  (0 = inverted, 1 = true)
module logic_gate_identifier
    import lgi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       probe_a,
    output logic       probe_b,
    input  logic       probe_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic       op_valid,
    output logic       sel_group_o,
    output logic       sel_gate_o
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [1:0]       vec_q;
    logic [1:0]       vec_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             sample;
    decode_t          dec;

    // Last cycle of the current vector: capture probe_y on this edge.
    assign sample  = (state_q == APPLY) && (cnt_q == CNT_LAST);
    assign vec_nxt = vec_q + 2'd1;
    assign dec     = decode_tt(truth_table);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   if (sample && (vec_q == 2'd3)) state_d = DECODE;
            DECODE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            APPLY, DECODE: busy = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    // Vector sequencing, capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q       <= '0;
            cnt_q       <= '0;
            probe_a     <= 1'b0;
            probe_b     <= 1'b0;
            truth_table <= '0;
            op_valid    <= 1'b0;
            sel_group_o <= 1'b0;
            sel_gate_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        probe_a <= 1'b0;
                        probe_b <= 1'b0;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        truth_table[vec_q] <= probe_y;
                        cnt_q              <= '0;
                        if (vec_q != 2'd3) begin
                            vec_q   <= vec_nxt;
                            probe_a <= vec_nxt[1];
                            probe_b <= vec_nxt[0];
                        end else begin
                            // Park the operands so they are already 0 once
                            // the run returns to IDLE.
                            probe_a <= 1'b0;
                            probe_b <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DECODE: begin
                    op_valid    <= dec.valid;
                    sel_group_o <= dec.group;
                    sel_gate_o  <= dec.gate;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gate_identifier.sv
// Bench for logic_gate_identifier: three instances (SETTLE_CYCLES = 0, 1, 3),
// each probing its own model of the selectable logic unit. Stimulus pushes the
// expected result into a per-instance queue; a monitor pops on every done.
module tb_logic_gate_identifier;

    typedef struct {
        logic [3:0] tt;
        logic       v;
        logic       g;
        logic       t;
        int         c0;   // cycle count of the accepting edge
        int         lat;  // edges from accept to the edge entering DONE
    } exp_t;

    logic clk, rst_n;
    logic [2:0]      start, pa, pb, py, busy, done, ov, sg, st;
    logic [2:0][3:0] tt;
    logic [2:0]      grp_sel, gate_sel, tie1;

    exp_t sb [3][$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    function automatic int settle_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // Behavioural selectable logic unit
    function automatic logic unit_fn(input logic a, input logic b,
                                     input logic g, input logic t);
        logic y;
        y = g ? (a | b) : (a & b);
        return t ? y : ~y;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic_gate_identifier #(
            .SETTLE_CYCLES((k == 0) ? 0 : ((k == 1) ? 1 : 3))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start[k]),
            .probe_a     (pa[k]),
            .probe_b     (pb[k]),
            .probe_y     (py[k]),
            .busy        (busy[k]),
            .done        (done[k]),
            .truth_table (tt[k]),
            .op_valid    (ov[k]),
            .sel_group_o (sg[k]),
            .sel_gate_o  (st[k])
        );
        assign py[k] = tie1[k] ? 1'b1 : unit_fn(pa[k], pb[k], grp_sel[k], gate_sel[k]);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: sweep the unit over all operands, then identify the table
    // by searching all four select codes.
    function automatic exp_t model(input logic g, input logic t, input logic tie);
        exp_t e;
        logic [3:0] cand;
        logic [1:0] v;
        for (int ab = 0; ab < 4; ab++) begin
            v = 2'(ab);
            e.tt[v] = tie ? 1'b1 : unit_fn(v[1], v[0], g, t);
        end
        e.v = 1'b0; e.g = 1'b0; e.t = 1'b0;
        for (int gg = 0; gg < 2; gg++)
            for (int tg = 0; tg < 2; tg++) begin
                for (int ab = 0; ab < 4; ab++) begin
                    v = 2'(ab);
                    cand[v] = unit_fn(v[1], v[0], gg[0], tg[0]);
                end
                if (cand == e.tt) begin
                    e.v = 1'b1; e.g = gg[0]; e.t = tg[0];
                end
            end
        e.c0 = 0; e.lat = 0;
        return e;
    endfunction

    // Monitor: pops and compares whenever an instance pulses done.
    initial begin
        logic [2:0] dprev;
        exp_t e;
        dprev = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    chk($sformatf("done_width%0d", k), 32'(dprev[k]), 32'd0);
                    chk($sformatf("busy_in_done%0d", k), 32'(busy[k]), 32'd0);
                    if (sb[k].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done%0d: got pulse expected none", k);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("truth_table%0d", k), 32'(tt[k]), 32'(e.tt));
                        chk($sformatf("op_valid%0d", k),    32'(ov[k]), 32'(e.v));
                        chk($sformatf("sel_group%0d", k),   32'(sg[k]), 32'(e.g));
                        chk($sformatf("sel_gate%0d", k),    32'(st[k]), 32'(e.t));
                        chk($sformatf("latency%0d", k),     32'(cyc - e.c0), 32'(e.lat));
                    end
                end
                dprev[k] = done[k];
            end
        end
    end

    // One identification run; called at a negedge.
    task automatic run(input int k, input logic g, input logic t,
                       input logic tie, input logic hold);
        exp_t e;
        int   s;
        bit   seen;
        s = settle_of(k);
        grp_sel[k] = g; gate_sel[k] = t; tie1[k] = tie;
        e = model(g, t, tie);
        e.c0  = cyc + 1;
        e.lat = 4 * (s + 1) + 1;
        sb[k].push_back(e);
        start[k] = 1'b1;
        seen = 0;
        for (int j = 0; j < 200 && !seen; j++) begin
            @(negedge clk);
            if (!hold) start[k] = 1'b0;
            if (j < 4 * (s + 1)) begin
                chk("probe_vec", 32'({pa[k], pb[k]}), 32'(j / (s + 1)));
                chk("busy_run", 32'(busy[k]), 32'd1);
            end
            if (done[k]) seen = 1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout%0d: got no done expected one", k);
        end
        start[k] = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy[k]), 32'd0);
        chk("idle_probes", 32'({pa[k], pb[k]}), 32'd0);
    endtask

    // Start a run and assert reset asynchronously during vector 2.
    task automatic abort_run(input int k);
        int s;
        s = settle_of(k);
        grp_sel[k] = 1'b1; gate_sel[k] = 1'b1; tie1[k] = 1'b0;
        start[k] = 1'b1;
        for (int j = 0; j <= 2 * (s + 1); j++) begin
            @(negedge clk);
            start[k] = 1'b0;
        end
        chk("abort_vec2", 32'({pa[k], pb[k]}), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_probes", 32'({pa[k], pb[k]}), 32'd0);
        chk("rst_busy",   32'(busy[k]), 32'd0);
        chk("rst_done",   32'(done[k]), 32'd0);
        chk("rst_tt",     32'(tt[k]), 32'd0);
        chk("rst_dec",    32'({ov[k], sg[k], st[k]}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(busy[k]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0; grp_sel = '0; gate_sel = '0; tie1 = '0;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("reset_state", 32'({pa[k], pb[k], busy[k], done[k], tt[k], ov[k], sg[k], st[k]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: AND, NAND, OR, NOR, stuck-at-1 output
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(1, 1'b1, 1'b1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1, 1'b1, 1'b0);
        // start held high through the whole run
        run(1, 1'b1, 1'b1, 1'b0, 1'b1);
        // Reset mid-run after a valid result, then a clean run
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        abort_run(1);
        run(1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Other settle lengths, all four codes
        for (int k = 0; k < 3; k += 2)
            for (int c = 0; c < 4; c++) begin
                logic [1:0] cc;
                cc = 2'(c);
                run(k, cc[1], cc[0], 1'b0, 1'b0);
            end
        // Randomized runs across instances
        for (int i = 0; i < 30; i++)
            run(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0));

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("sb_empty", 32'(sb[k].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
